// File: rtl/sort_check8.sv
// sort_check8: checks an 8-word sorter result for ascending order and a sum/XOR permutation signature
module sort_check8 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic [WIDTH-1:0] in6,
  input  logic [WIDTH-1:0] in7,
  input  logic             done,
  input  logic [WIDTH-1:0] out0,
  input  logic [WIDTH-1:0] out1,
  input  logic [WIDTH-1:0] out2,
  input  logic [WIDTH-1:0] out3,
  input  logic [WIDTH-1:0] out4,
  input  logic [WIDTH-1:0] out5,
  input  logic [WIDTH-1:0] out6,
  input  logic [WIDTH-1:0] out7,
  output logic             busy,
  output logic             check_done,
  output logic             pass,
  output logic             err_order,
  output logic             err_perm,
  output logic [2:0]       fail_idx,
  output logic [15:0]      checks_run,
  output logic [15:0]      checks_failed
);
  typedef enum logic [1:0] {IDLE, ARMED, SCAN, REPORT} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] ins [8];
  logic [WIDTH-1:0] outs [8];
  logic [WIDTH-1:0] o [8];
  logic [WIDTH+2:0] isum, osum, nsum_i, nsum_o;
  logic [WIDTH-1:0] ixor, oxor, nxor_i, nxor_o;
  logic [2:0] idx, fi, fi_f;
  logic ord, bad, ord_f, perm;
  logic cap_in, cap_out;
  assign ins  = '{in0, in1, in2, in3, in4, in5, in6, in7};
  assign outs = '{out0, out1, out2, out3, out4, out5, out6, out7};
  assign busy       = state != IDLE;
  assign check_done = state == REPORT;
  assign cap_in  = (state == IDLE || state == ARMED) && start;
  assign cap_out = state == ARMED && !start && done;
  // Signatures of the live input and output vectors; sum is widened so it never truncates
  always_comb begin
    nsum_i = '0;
    nsum_o = '0;
    nxor_i = '0;
    nxor_o = '0;
    for (int k = 0; k < 8; k++) begin
      nsum_i = nsum_i + {3'b000, ins[k]};
      nsum_o = nsum_o + {3'b000, outs[k]};
      nxor_i = nxor_i ^ ins[k];
      nxor_o = nxor_o ^ outs[k];
    end
  end
  // Current pair compare, folded with earlier results to give the final verdict on the last pair
  always_comb begin
    bad   = o[idx] > o[idx + 3'd1];
    ord_f = ord | bad;
    fi_f  = ord ? fi : (bad ? idx : 3'd0);
    perm  = (isum != osum) || (ixor != oxor);
  end
  // Next-state logic; start outranks done while armed
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? ARMED : IDLE;
      ARMED:   state_n = start ? ARMED : (done ? SCAN : ARMED);
      SCAN:    state_n = idx == 3'd6 ? REPORT : SCAN;
      default: state_n = IDLE;
    endcase
  end
  // State, captured data, scan progress and verdict registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      o             <= '{default: '0};
      isum          <= '0;
      osum          <= '0;
      ixor          <= '0;
      oxor          <= '0;
      idx           <= '0;
      fi            <= '0;
      ord           <= 1'b0;
      pass          <= 1'b0;
      err_order     <= 1'b0;
      err_perm      <= 1'b0;
      fail_idx      <= '0;
      checks_run    <= '0;
      checks_failed <= '0;
    end else begin
      state <= state_n;
      if (cap_in) begin
        isum <= nsum_i;
        ixor <= nxor_i;
      end
      if (cap_out) begin
        o    <= outs;
        osum <= nsum_o;
        oxor <= nxor_o;
        idx  <= '0;
        fi   <= '0;
        ord  <= 1'b0;
      end
      if (state == SCAN) begin
        idx <= idx + 3'd1;
        ord <= ord_f;
        fi  <= fi_f;
        if (idx == 3'd6) begin
          err_order     <= ord_f;
          fail_idx      <= fi_f;
          err_perm      <= perm;
          pass          <= !ord_f && !perm;
          checks_run    <= checks_run + {15'd0, checks_run != 16'hFFFF};
          checks_failed <= checks_failed + {15'd0, (ord_f || perm) && checks_failed != 16'hFFFF};
        end
      end
    end
  end
endmodule

// File: tb/tb_sort_check8.sv
// tb_sort_check8: directed scoreboard bench for sort_check8
module tb_sort_check8;
  logic clk = 1'b0;
  logic rst, start, done;
  logic [31:0] iv [8];
  logic [31:0] ov [8];
  logic busy, check_done, pass, err_order, err_perm;
  logic [2:0] fail_idx;
  logic [15:0] checks_run, checks_failed;
  typedef struct {
    logic p, eo, ep;
    logic [2:0] fi;
    logic [15:0] run, fl;
  } exp_t;
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  logic [15:0] exp_run = 0;
  logic [15:0] exp_fail = 0;

  always #5 clk = ~clk;

  sort_check8 dut (
    .clk(clk), .rst(rst), .start(start),
    .in0(iv[0]), .in1(iv[1]), .in2(iv[2]), .in3(iv[3]),
    .in4(iv[4]), .in5(iv[5]), .in6(iv[6]), .in7(iv[7]),
    .done(done),
    .out0(ov[0]), .out1(ov[1]), .out2(ov[2]), .out3(ov[3]),
    .out4(ov[4]), .out5(ov[5]), .out6(ov[6]), .out7(ov[7]),
    .busy(busy), .check_done(check_done), .pass(pass),
    .err_order(err_order), .err_perm(err_perm), .fail_idx(fail_idx),
    .checks_run(checks_run), .checks_failed(checks_failed)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model();
    exp_t e;
    logic [34:0] si, so;
    logic [31:0] xi, xo;
    si = '0; so = '0; xi = '0; xo = '0;
    e.eo = 1'b0;
    e.fi = 3'd0;
    for (int i = 0; i < 8; i++) begin
      si += {3'b000, iv[i]};
      so += {3'b000, ov[i]};
      xi ^= iv[i];
      xo ^= ov[i];
    end
    for (int i = 0; i < 7; i++)
      if (!e.eo && ov[i] > ov[i+1]) begin
        e.eo = 1'b1;
        e.fi = 3'(i);
      end
    e.ep = (si != so) || (xi != xo);
    e.p  = !e.eo && !e.ep;
    return e;
  endfunction

  task automatic set_in(input int a0, a1, a2, a3, a4, a5, a6, a7);
    iv = '{a0, a1, a2, a3, a4, a5, a6, a7};
  endtask

  task automatic set_out(input int a0, a1, a2, a3, a4, a5, a6, a7);
    ov = '{a0, a1, a2, a3, a4, a5, a6, a7};
  endtask

  task automatic run_check(input string tag);
    exp_t e, g;
    int n;
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, ".armed_busy"}, 32'(busy), 1);
    e = model();
    if (exp_run != 16'hFFFF) exp_run++;
    if (!e.p && exp_fail != 16'hFFFF) exp_fail++;
    e.run = exp_run;
    e.fl  = exp_fail;
    q.push_back(e);
    done = 1'b1;
    step();
    done = 1'b0;
    n = 1;
    while (!check_done && n < 16) begin
      step();
      n++;
    end
    chk({tag, ".latency"}, 32'(n), 8);
    g = q.pop_front();
    chk({tag, ".pass"}, 32'(pass), 32'(g.p));
    chk({tag, ".err_order"}, 32'(err_order), 32'(g.eo));
    chk({tag, ".err_perm"}, 32'(err_perm), 32'(g.ep));
    chk({tag, ".fail_idx"}, 32'(fail_idx), 32'(g.fi));
    chk({tag, ".checks_run"}, 32'(checks_run), 32'(g.run));
    chk({tag, ".checks_failed"}, 32'(checks_failed), 32'(g.fl));
    step();
    chk({tag, ".pulse_one"}, 32'(check_done), 0);
    chk({tag, ".idle"}, 32'(busy), 0);
    chk({tag, ".hold_pass"}, 32'(pass), 32'(g.p));
  endtask

  initial begin
    logic [31:0] t;
    int seen;
    rst = 1'b1; start = 1'b0; done = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    set_out(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    rst = 1'b0;
    chk("reset.busy", 32'(busy), 0);
    chk("reset.check_done", 32'(check_done), 0);
    chk("reset.pass", 32'(pass), 0);
    chk("reset.checks_run", 32'(checks_run), 0);

    set_in(56, 12, 89, 33, 7, 98, 45, 21);
    set_out(7, 12, 21, 33, 45, 56, 89, 98);
    run_check("good");
    chk("good.direct_pass", 32'(pass), 1);
    set_out(7, 12, 33, 21, 45, 56, 89, 98);
    run_check("order");
    chk("order.direct_idx", 32'(fail_idx), 2);
    set_out(7, 12, 21, 33, 45, 56, 89, 99);
    run_check("perm");
    chk("perm.direct_flag", 32'(err_perm), 1);
    set_out(98, 12, 21, 33, 45, 56, 89, 7);
    run_check("multi_order");

    done = 1'b1;
    step();
    done = 1'b0;
    chk("stray_done.busy", 32'(busy), 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (check_done) seen++;
    end
    chk("stray_done.no_pulse", 32'(seen), 0);
    chk("stray_done.run", 32'(checks_run), 32'(exp_run));

    start = 1'b1;
    step();
    done = 1'b1;
    step();
    start = 1'b0; done = 1'b0;
    step();
    chk("start_done.armed", 32'(busy), 1);
    chk("start_done.no_pulse", 32'(check_done), 0);
    set_out(7, 12, 21, 33, 45, 56, 89, 98);
    run_check("after_armed");

    start = 1'b1;
    step();
    start = 1'b0;
    done = 1'b1;
    step();
    done = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_run = 0;
    exp_fail = 0;
    chk("abort.busy", 32'(busy), 0);
    chk("abort.pass", 32'(pass), 0);
    chk("abort.err_perm", 32'(err_perm), 0);
    chk("abort.checks_run", 32'(checks_run), 0);
    chk("abort.checks_failed", 32'(checks_failed), 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (check_done) seen++;
    end
    chk("abort.no_pulse", 32'(seen), 0);
    run_check("post_abort");
    chk("post_abort.run1", 32'(checks_run), 1);

    set_in(5, 5, 5, 5, 5, 5, 5, 5);
    set_out(5, 5, 5, 5, 5, 5, 5, 5);
    run_check("equal");
    set_in(56, 12, 89, 33, 7, 98, 45, 21);
    set_out(7, 12, 21, 33, 45, 56, 89, 98);
    run_check("b2b_a");
    run_check("b2b_b");

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) iv[i] = $urandom;
      ov = iv;
      for (int i = 0; i < 7; i++)
        for (int j = 0; j < 7 - i; j++)
          if (ov[j] > ov[j+1]) begin
            t = ov[j]; ov[j] = ov[j+1]; ov[j+1] = t;
          end
      run_check($sformatf("rand%0d", r));
    end
    ov[3] = ov[3] ^ 32'h1;
    run_check("rand_bad");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
